// File: rtl/action_input_conditioner.sv
// rtl/action_input_conditioner.sv - per-player button debounce, priority encode, cooldown; auto-repeat when ACTION_REPEAT_EN is defined
module action_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [5:0] player1,
  input  logic [5:0] player2,
  output logic [2:0] p1_action,
  output logic       p1_valid,
  output logic       p1_busy,
  output logic [2:0] p2_action,
  output logic       p2_valid,
  output logic       p2_busy
);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    FIRE,
    COOLDOWN,
    WAIT_RELEASE
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] CD_LAST  = 8'(COOLDOWN_CYCLES - 1);
`ifdef ACTION_REPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_CYCLES - 1);
`endif

  // Reject out-of-range timing parameters at elaboration so the 8-bit counters never wrap.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > 255) begin : g_bad_param
    $error("action_input_conditioner: timing parameters must be within 1..255");
  end

  // Lowest set bit wins; code is bit index + 1, zero when no bit is set.
  function automatic logic [2:0] prio_code(input logic [5:0] pattern);
    prio_code = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pattern[i]) prio_code = 3'(i + 1);
    end
  endfunction

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [5:0] raw;
    logic [5:0] sync_a;
    logic [5:0] sync_b;
    logic [5:0] latched;
    logic [5:0] latched_d;
    logic [7:0] count;
    logic [7:0] count_d;
    state_t     state;
    state_t     state_d;
    logic [2:0] act;
    logic       vld;
    logic       bsy;

    assign raw = (p == 0) ? player1 : player2;

    // Two-flop synchronizer on the raw buttons, running every clock regardless of tick.
    always_ff @(posedge clock) begin
      if (!reset) begin
        sync_a <= '0;
        sync_b <= '0;
      end else begin
        sync_a <= raw;
        sync_b <= sync_a;
      end
    end

    // State, counter and latched pattern registers.
    always_ff @(posedge clock) begin
      if (!reset) begin
        state   <= IDLE;
        count   <= '0;
        latched <= '0;
      end else begin
        state   <= state_d;
        count   <= count_d;
        latched <= latched_d;
      end
    end

    // Next-state and output decode; FIRE is a single clock independent of tick.
    always_comb begin
      state_d   = state;
      count_d   = count;
      latched_d = latched;
      act       = 3'd0;
      vld       = 1'b0;
      bsy       = 1'b0;
      case (state)
        IDLE: begin
          if (tick && sync_b != 6'd0) begin
            latched_d = sync_b;
            count_d   = 8'd0;
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (sync_b == 6'd0) begin
              state_d = IDLE;
            end else if (sync_b != latched) begin
              latched_d = sync_b;
              count_d   = 8'd0;
            end else if (count == DEB_LAST) begin
              state_d = FIRE;
            end else begin
              count_d = count + 8'd1;
            end
          end
        end
        FIRE: begin
          vld     = 1'b1;
          act     = prio_code(latched);
          bsy     = 1'b1;
          count_d = 8'd0;
          state_d = COOLDOWN;
        end
        COOLDOWN: begin
          bsy = 1'b1;
          if (tick) begin
            if (count == CD_LAST) begin
              count_d = 8'd0;
              state_d = WAIT_RELEASE;
            end else begin
              count_d = count + 8'd1;
            end
          end
        end
        WAIT_RELEASE: begin
          bsy = 1'b1;
          if (tick) begin
            if (sync_b == 6'd0) begin
              state_d = IDLE;
            end
`ifdef ACTION_REPEAT_EN
            else if (sync_b == latched) begin
              if (count == REP_LAST) begin
                state_d = FIRE;
              end else begin
                count_d = count + 8'd1;
              end
            end else begin
              count_d = 8'd0;
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign p1_action = g_player[0].act;
  assign p1_valid  = g_player[0].vld;
  assign p1_busy   = g_player[0].bsy;
  assign p2_action = g_player[1].act;
  assign p2_valid  = g_player[1].vld;
  assign p2_busy   = g_player[1].bsy;

endmodule

// File: tb/tb_action_input_conditioner.sv
// tb/tb_action_input_conditioner.sv - scoreboard bench for action_input_conditioner
module tb_action_input_conditioner;

  localparam int DEB  = 4;
  localparam int COOL = 8;
  localparam int REP  = 16;
`ifdef ACTION_REPEAT_EN
  localparam int HOLD40_PULSES = 2;
`else
  localparam int HOLD40_PULSES = 1;
`endif

  logic       clock;
  logic       reset;
  logic       tick;
  logic [5:0] player1;
  logic [5:0] player2;
  logic [2:0] p1_action;
  logic       p1_valid;
  logic       p1_busy;
  logic [2:0] p2_action;
  logic       p2_valid;
  logic       p2_busy;

  action_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .COOLDOWN_CYCLES(COOL),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .player1  (player1),
    .player2  (player2),
    .p1_action(p1_action),
    .p1_valid (p1_valid),
    .p1_busy  (p1_busy),
    .p2_action(p2_action),
    .p2_valid (p2_valid),
    .p2_busy  (p2_busy)
  );

  typedef struct {
    int         cyc;
    logic [2:0] act;
  } pulse_t;

  pulse_t exp_q [2][$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  bit     mon_on = 0;
  bit     exp_busy [2];
  int     tick_mode = 0;
  int     tick_div = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [2:0] lowest_code(input logic [5:0] v);
    for (int i = 0; i < 6; i++) begin
      if (v[i]) return 3'(i + 1);
    end
    return 3'd0;
  endfunction

  // Reference model: buttons seen two clocks late; a press fires once the same nonzero
  // pattern has been seen on DEB+1 consecutive ticks; then a one-clock pulse, COOL ticks
  // of lockout, and a wait for a released (zero) sample on a tick.
  initial begin : model
    logic [5:0] raw;
    logic [5:0] s;
    logic [5:0] s1 [2];
    logic [5:0] s2 [2];
    logic [5:0] pat [2];
    int         run [2];
    int         cool_left [2];
    int         hold [2];
    bit         firing [2];
    bit         need_release [2];
    bit         fire;
    for (int p = 0; p < 2; p++) begin
      s1[p] = 0; s2[p] = 0; pat[p] = 0; run[p] = 0; cool_left[p] = 0;
      hold[p] = 0; firing[p] = 0; need_release[p] = 0; exp_busy[p] = 0;
    end
    forever begin
      @(posedge clock);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        raw  = (p == 0) ? player1 : player2;
        s    = s2[p];
        fire = 1'b0;
        if (!reset) begin
          s1[p] = 0; s2[p] = 0; pat[p] = 0; run[p] = 0; cool_left[p] = 0;
          hold[p] = 0; firing[p] = 0; need_release[p] = 0;
        end else begin
          s2[p] = s1[p];
          s1[p] = raw;
          if (firing[p]) begin
            firing[p]    = 0;
            cool_left[p] = COOL;
          end else if (tick) begin
            if (cool_left[p] > 0) begin
              cool_left[p]--;
              if (cool_left[p] == 0) begin
                need_release[p] = 1;
                hold[p]         = 0;
              end
            end else if (need_release[p]) begin
              if (s == 0) begin
                need_release[p] = 0;
                run[p]          = 0;
              end
`ifdef ACTION_REPEAT_EN
              else if (s == pat[p]) begin
                hold[p]++;
                if (hold[p] == REP) begin
                  need_release[p] = 0;
                  fire            = 1'b1;
                end
              end else begin
                hold[p] = 0;
              end
`endif
            end else begin
              if (s == 0) begin
                run[p] = 0;
              end else if (run[p] > 0 && s == pat[p]) begin
                run[p]++;
              end else begin
                pat[p] = s;
                run[p] = 1;
              end
              if (run[p] == DEB + 1) begin
                run[p] = 0;
                fire   = 1'b1;
              end
            end
          end
        end
        if (fire) begin
          firing[p] = 1;
          exp_q[p].push_back('{cyc, lowest_code(pat[p])});
        end
        exp_busy[p] = firing[p] || (cool_left[p] > 0) || need_release[p];
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin : monitor
    logic       v;
    logic [2:0] a;
    logic       b;
    pulse_t     e;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        for (int p = 0; p < 2; p++) begin
          v = (p == 0) ? p1_valid : p2_valid;
          a = (p == 0) ? p1_action : p2_action;
          b = (p == 0) ? p1_busy : p2_busy;
          while (exp_q[p].size() > 0 && exp_q[p][0].cyc < cyc) begin
            e = exp_q[p].pop_front();
            n_cmp++; n_err++;
            $display("FAIL p%0d missed_pulse: got no pulse, expected code %0d at cycle %0d", p + 1, e.act, e.cyc);
          end
          if (v === 1'b1) begin
            n_cmp++;
            if (exp_q[p].size() == 0) begin
              n_err++;
              $display("FAIL p%0d unexpected_pulse: code %0d at cycle %0d, expected no pulse", p + 1, a, cyc);
            end else begin
              e = exp_q[p].pop_front();
              if (e.cyc != cyc || e.act !== a) begin
                n_err++;
                $display("FAIL p%0d pulse: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                         p + 1, a, cyc, e.act, e.cyc);
              end
            end
          end else begin
            n_cmp++;
            if (v !== 1'b0 || a !== 3'd0) begin
              n_err++;
              $display("FAIL p%0d idle_outputs: valid=%b action=%0d at cycle %0d, expected 0/0", p + 1, v, a, cyc);
            end
          end
          n_cmp++;
          if (b !== exp_busy[p]) begin
            n_err++;
            $display("FAIL p%0d busy: got %b at cycle %0d, expected %b", p + 1, b, cyc, exp_busy[p]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
    tick_div++;
    case (tick_mode)
      0:       tick = 1'b1;
      1:       tick = (tick_div % 4 == 0);
      default: tick = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic watch(input int p, input int n, output int first, output int count, output int act);
    first = -1; count = 0; act = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (((p == 0) ? p1_valid : p2_valid) === 1'b1) begin
        if (first < 0) begin
          first = k;
          act   = (p == 0) ? int'(p1_action) : int'(p2_action);
        end
        count++;
      end
    end
  endtask

  function automatic logic [5:0] rand_pat();
    int r;
    logic [5:0] one;
    r   = $urandom_range(0, 9);
    one = 6'd1;
    if (r < 4) return 6'd0;
    if (r < 7) return one << $urandom_range(0, 5);
    return 6'($urandom_range(1, 63));
  endfunction

  initial begin : stimulus
    int first;
    int count;
    int act;
    int hold1;
    int hold2;
    bit seen;
    reset = 1'b0; tick = 1'b1; player1 = 6'd0; player2 = 6'd0;
    repeat (3) @(negedge clock);
    check("reset_p1_valid", int'(p1_valid), 0);
    check("reset_p1_action", int'(p1_action), 0);
    check("reset_p1_busy", int'(p1_busy), 0);
    check("reset_p2_valid", int'(p2_valid), 0);
    check("reset_p2_action", int'(p2_action), 0);
    check("reset_p2_busy", int'(p2_busy), 0);
    mon_on = 1;
    reset  = 1'b1;
    steps(3);

    // Held press: latency, code, single pulse while held.
    player1 = 6'b000100;
    watch(0, 40, first, count, act);
    check("hold_latency", first, DEB + 2);
    check("hold_code", act, 3);
    check("hold_pulse_count", count, HOLD40_PULSES);
    player1 = 6'd0;
    steps(20);

    // Two-cycle glitch never fires.
    player1 = 6'b000001;
    steps(2);
    player1 = 6'd0;
    watch(0, 12, first, count, act);
    check("glitch_pulses", count, 0);
    check("glitch_busy", int'(p1_busy), 0);

    // Both players in the same cycle.
    player1 = 6'b101010;
    player2 = 6'b010000;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (!seen && (p1_valid === 1'b1 || p2_valid === 1'b1)) begin
        seen = 1;
        check("dual_same_cycle", int'({p1_valid, p2_valid}), 3);
        check("dual_p1_code", int'(p1_action), 2);
        check("dual_p2_code", int'(p2_action), 5);
      end
    end
    check("dual_seen", int'(seen), 1);
    player1 = 6'd0; player2 = 6'd0;
    steps(20);

    // Slow tick, one in four cycles.
    tick_mode = 1;
    player2   = 6'b000010;
    watch(1, 60, first, count, act);
    check("slow_tick_pulses", count, 1);
    check("slow_tick_code", act, 2);
    player2 = 6'd0;
    steps(40);
    tick_mode = 0;
    steps(4);

    // Reset during debounce, then during cooldown, with the button held throughout.
    player1 = 6'b000100;
    steps(4);
    reset = 1'b0;
    step();
    check("rst_deb_busy", int'(p1_busy), 0);
    check("rst_deb_valid", int'(p1_valid), 0);
    reset = 1'b1;
    watch(0, 10, first, count, act);
    check("rst_deb_relatency", first, DEB + 2);
    check("rst_deb_pulses", count, 1);
    reset = 1'b0;
    step();
    check("rst_cool_busy", int'(p1_busy), 0);
    check("rst_cool_action", int'(p1_action), 0);
    reset = 1'b1;
    watch(0, 12, first, count, act);
    check("rst_cool_relatency", first, DEB + 2);
    check("rst_cool_pulses", count, 1);
    player1 = 6'd0;
    steps(30);

    // Randomized traffic: tick always on, then random tick.
    for (int round = 0; round < 2; round++) begin
      tick_mode = (round == 0) ? 0 : 2;
      hold1 = 0; hold2 = 0;
      for (int i = 0; i < 3000; i++) begin
        if (hold1 == 0) begin
          player1 = rand_pat();
          hold1   = $urandom_range(1, 40);
        end else begin
          hold1--;
        end
        if (hold2 == 0) begin
          player2 = rand_pat();
          hold2   = $urandom_range(1, 40);
        end else begin
          hold2--;
        end
        reset = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    reset = 1'b1; player1 = 6'd0; player2 = 6'd0; tick_mode = 0;
    steps(60);
    check("queue_drained", exp_q[0].size() + exp_q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
